instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Inverse of the control decoder: turns field-level instruction requests (mnemonic ID plus register, shamt and immediate fields) into 32-bit MIPS machine words and writes them sequentially into instruction memory. Used by the bench/boot loader to build programs in IM without an external assembler. Covers exactly the instruction set the datapath decodes. Valid/ready input, one-entry output register toward the IM write port, sticky error flags.

Parameters:
ADDR_W, 10, IM word-address width; write address wraps modulo 2^ADDR_W
CNT_W, 16, width of the emitted-word counter

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  pulse; accepted only in IDLE; loads base_addr
base_addr  in  ADDR_W  first IM word address
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_mnem  in  6  mnemonic ID (shared package enumeration)
in_rs / in_rt / in_rd  in  5 each  register fields
in_shamt  in  5  shift amount
in_imm  in  26  immediate; I-type uses [15:0], J-type uses all 26 bits (word target)
in_last  in  1  marks final request of the program
im_we  out  1  IM write strobe (output register valid)
im_addr  out  ADDR_W  IM word address
im_wdata  out  32  encoded instruction
im_ready  in  1  IM accepts the write this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at program completion
count  out  CNT_W  words written since start (saturates at all-ones)
err_illegal  out  1  sticky: unknown mnemonic seen
err_range  out  1  sticky: immediate out of range

Behaviour:
- Reset (async, rstn=0): state IDLE; in_ready, im_we, busy, done, err_* = 0; im_addr, im_wdata, count = 0.
- FSM IDLE -> RUN on start (im_addr<=base_addr, count<=0, err_* <=0). RUN -> DRAIN on accepted in_last. DRAIN -> DONE when output register empty (or becomes empty this cycle). DONE -> IDLE next cycle; done=1 only in DONE. start outside IDLE ignored.
- in_ready = (state==RUN) && (!im_we || im_ready). Accepted request appears on im_wdata/im_we next cycle (latency 1). Full throughput with im_ready held high.
- im_we stays high, im_addr/im_wdata stable, while im_ready=0. On im_we && im_ready: im_addr+1 (wrap to 0 after 2^ADDR_W-1), count+1 (saturating).
- Simultaneous transfer-out and accept-in in the same cycle: register reloads, im_we stays 1.
- Encoding: R-type {0,rs,rt,rd,0,funct} for ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLLV/SRLV/SRAV; SLL/SRL/SRA {0,0,rt,rd,shamt,funct}; JR {0,rs,0,0,0,08}; JALR {0,rs,0,rd,0,09}; I-type {op,rs,rt,imm16} for ADDI/SLTI/ANDI/ORI/loads/stores/BEQ/BNE; LUI rs field forced 0; J/JAL {op,imm26}. Opcode/funct values come from the existing instruction definition macros.
- Range: signed ops (ADDI, SLTI, loads, stores, BEQ, BNE) require in_imm[25:16] all equal to in_imm[15]; ANDI/ORI/LUI require in_imm[25:16]==0. On violation: set err_range, still emit the truncated imm16.
- Unknown in_mnem: emit 0x00000000 (NOP), set err_illegal, still consumes an address.
- Unused input fields are ignored; they are never ORed into the word.
- Reset mid-program: everything returns to reset values; partial program is abandoned.

Decomposition:
- Shared package: mnemonic ID enumeration, format-class constants (R, SHIFT, JR, JALR, I_SIGNED, I_UNSIGNED, LUI, J), FSM state encoding. Opcode/funct values reuse the existing instruction definition include.
- One sub-module: instr_fmt_enc, purely combinational (mnemonic + fields -> word, illegal, range_err). The top holds the FSM, the output register, and the address/count logic.

Test Plan:
- start base_addr=0x010; ADD rs=1 rt=2 rd=3, then ADDI rs=1 rt=2 imm=0x3FFFFFC (last); im_ready=1 -> writes 0x00221820 @0x010 and 0x2022FFFC @0x011; done pulse 1 cycle; count=2.
- SLL rt=2 rd=4 shamt=3 with in_rs=7 -> 0x000220C0 (rs ignored); J imm=0x0100000 -> 0x08100000.
- ORI imm=0x0010000 -> err_range=1, word imm16=0x0000; undefined in_mnem -> word 0x00000000, err_illegal=1; both flags stay set until next start.
- Hold im_ready=0 for 3 cycles with valid stream -> in_ready=0, im_we/im_addr/im_wdata stable; release -> no word lost or duplicated, addresses contiguous.
- base_addr=2^ADDR_W-1, two words -> second at address 0.
- Deassert rstn mid-stream -> all outputs 0 immediately; new start re-runs cleanly; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: mnemonic IDs, format classes,
// FSM state encoding and the MIPS opcode/funct values used by the datapath.
// Pure declarations; no logic.
package instr_encoder_pkg;

  // Mnemonic IDs presented on in_mnem; any value above M_JAL is illegal
  typedef enum logic [5:0] {
    M_ADD  = 6'd0,  M_ADDU = 6'd1,  M_SUB  = 6'd2,  M_SUBU = 6'd3,
    M_AND  = 6'd4,  M_OR   = 6'd5,  M_XOR  = 6'd6,  M_NOR  = 6'd7,
    M_SLT  = 6'd8,  M_SLTU = 6'd9,  M_SLLV = 6'd10, M_SRLV = 6'd11,
    M_SRAV = 6'd12, M_SLL  = 6'd13, M_SRL  = 6'd14, M_SRA  = 6'd15,
    M_JR   = 6'd16, M_JALR = 6'd17, M_ADDI = 6'd18, M_SLTI = 6'd19,
    M_ANDI = 6'd20, M_ORI  = 6'd21, M_LUI  = 6'd22, M_LW   = 6'd23,
    M_LB   = 6'd24, M_LBU  = 6'd25, M_LH   = 6'd26, M_LHU  = 6'd27,
    M_SW   = 6'd28, M_SB   = 6'd29, M_SH   = 6'd30, M_BEQ  = 6'd31,
    M_BNE  = 6'd32, M_J    = 6'd33, M_JAL  = 6'd34
  } mnem_e;

  // Field layout class of an instruction
  typedef enum logic [2:0] {
    FMT_R, FMT_SHIFT, FMT_JR, FMT_JALR, FMT_I_SIGNED, FMT_I_UNSIGNED, FMT_LUI, FMT_J
  } fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F, OP_LB   = 6'h20, OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23, OP_LBU  = 6'h24, OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  // Function codes for SPECIAL
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

endpackage

// File: rtl/instr_encoder_fmt_enc.sv
// Encodes one mnemonic plus its fields into a 32-bit MIPS word.
// Purely combinational, zero latency.
// No backpressure; flags illegal mnemonics and out-of-range immediates.
module instr_fmt_enc
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  fmt_e       cls;
  logic [5:0] op;
  logic [5:0] fn;

  // Classify the mnemonic and look up its opcode / funct
  always_comb begin
    cls     = FMT_R;
    op      = OP_SPECIAL;
    fn      = FN_SLL;
    illegal = 1'b0;
    case (mnem)
      M_ADD:  fn = FN_ADD;
      M_ADDU: fn = FN_ADDU;
      M_SUB:  fn = FN_SUB;
      M_SUBU: fn = FN_SUBU;
      M_AND:  fn = FN_AND;
      M_OR:   fn = FN_OR;
      M_XOR:  fn = FN_XOR;
      M_NOR:  fn = FN_NOR;
      M_SLT:  fn = FN_SLT;
      M_SLTU: fn = FN_SLTU;
      M_SLLV: fn = FN_SLLV;
      M_SRLV: fn = FN_SRLV;
      M_SRAV: fn = FN_SRAV;
      M_SLL:  begin cls = FMT_SHIFT;      fn = FN_SLL;  end
      M_SRL:  begin cls = FMT_SHIFT;      fn = FN_SRL;  end
      M_SRA:  begin cls = FMT_SHIFT;      fn = FN_SRA;  end
      M_JR:   begin cls = FMT_JR;         fn = FN_JR;   end
      M_JALR: begin cls = FMT_JALR;       fn = FN_JALR; end
      M_ADDI: begin cls = FMT_I_SIGNED;   op = OP_ADDI; end
      M_SLTI: begin cls = FMT_I_SIGNED;   op = OP_SLTI; end
      M_ANDI: begin cls = FMT_I_UNSIGNED; op = OP_ANDI; end
      M_ORI:  begin cls = FMT_I_UNSIGNED; op = OP_ORI;  end
      M_LUI:  begin cls = FMT_LUI;        op = OP_LUI;  end
      M_LW:   begin cls = FMT_I_SIGNED;   op = OP_LW;   end
      M_LB:   begin cls = FMT_I_SIGNED;   op = OP_LB;   end
      M_LBU:  begin cls = FMT_I_SIGNED;   op = OP_LBU;  end
      M_LH:   begin cls = FMT_I_SIGNED;   op = OP_LH;   end
      M_LHU:  begin cls = FMT_I_SIGNED;   op = OP_LHU;  end
      M_SW:   begin cls = FMT_I_SIGNED;   op = OP_SW;   end
      M_SB:   begin cls = FMT_I_SIGNED;   op = OP_SB;   end
      M_SH:   begin cls = FMT_I_SIGNED;   op = OP_SH;   end
      M_BEQ:  begin cls = FMT_I_SIGNED;   op = OP_BEQ;  end
      M_BNE:  begin cls = FMT_I_SIGNED;   op = OP_BNE;  end
      M_J:    begin cls = FMT_J;          op = OP_J;    end
      M_JAL:  begin cls = FMT_J;          op = OP_JAL;  end
      default: illegal = 1'b1;
    endcase
  end

  // Assemble the word from the used fields only; an illegal mnemonic yields a NOP
  always_comb begin
    word      = 32'h0000_0000;
    range_err = 1'b0;
    if (!illegal) begin
      case (cls)
        FMT_R:     word = {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
        FMT_SHIFT: word = {OP_SPECIAL, 5'd0, rt, rd, shamt, fn};
        FMT_JR:    word = {OP_SPECIAL, rs, 15'd0, fn};
        FMT_JALR:  word = {OP_SPECIAL, rs, 5'd0, rd, 5'd0, fn};
        FMT_I_SIGNED: begin
          word      = {op, rs, rt, imm[15:0]};
          range_err = (imm[25:16] != {10{imm[15]}});
        end
        FMT_I_UNSIGNED: begin
          word      = {op, rs, rt, imm[15:0]};
          range_err = |imm[25:16];
        end
        FMT_LUI: begin
          word      = {op, 5'd0, rt, imm[15:0]};
          range_err = |imm[25:16];
        end
        default:   word = {op, imm};
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Builds a program in instruction memory from field-level requests, one word per accept.
// Latency 1 cycle from accepted request to im_we/im_wdata; full throughput with im_ready high.
// One-entry output register: in_ready drops while im_we is held waiting for im_ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              err_illegal,
  output logic              err_range
);

  state_e      state, state_nxt;
  logic [31:0] enc_word;
  logic        enc_illegal, enc_range;
  logic        accept, xfer, start_acc;

  instr_fmt_enc u_fmt_enc (
    .mnem      (in_mnem),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .shamt     (in_shamt),
    .imm       (in_imm),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range)
  );

  assign accept    = in_valid && in_ready;
  assign xfer      = im_we && im_ready;
  assign start_acc = start && (state == ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: drain waits until the output register is empty or empties this cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)                 state_nxt = ST_RUN;
      ST_RUN:   if (accept && in_last)     state_nxt = ST_DRAIN;
      ST_DRAIN: if (!im_we || im_ready)    state_nxt = ST_DONE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // State-derived outputs; a request can enter whenever the register frees up this cycle
  always_comb begin
    in_ready = (state == ST_RUN) && (!im_we || im_ready);
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
  end

  // Output register, write address, saturating count and sticky error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= 32'h0000_0000;
      count       <= '0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else if (start_acc) begin
      im_addr     <= base_addr;
      count       <= '0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (xfer) begin
        im_addr <= im_addr + 1'b1;
        if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
      end
      if (accept) begin
        im_we       <= 1'b1;
        im_wdata    <= enc_word;
        err_illegal <= err_illegal | enc_illegal;
        err_range   <= err_range | enc_range;
      end else if (xfer) begin
        im_we <= 1'b0;
      end
    end
  end

endmodule
